// File: rtl/bomb_pkg.sv
// Shared types and constants for the bomb placement and blast stages.
package bomb_pkg;

    typedef enum logic [2:0] {
        s_idle,
        s_armed,
        s_blink,
        s_detonate,
        s_wait
    } state_t;

    localparam int          TILE_LOG2 = 5;
    localparam logic [10:0] OFF_X     = 11'd640;
    localparam logic [10:0] OFF_Y     = 11'd480;

    typedef logic [1:0] radius_t;

    // Radius grows by one power-up at a time and sticks at the maximum.
    function automatic radius_t radius_inc(input radius_t r);
        return (r == 2'd3) ? r : r + 2'd1;
    endfunction

endpackage

// File: rtl/grid_snap.sv
// Rounds a signed sprite coordinate to the nearest tile boundary, clamping negatives to 0.
module grid_snap #(
    parameter int TILE_LOG2 = bomb_pkg::TILE_LOG2
) (
    input  logic signed [10:0] pos,
    output logic        [10:0] snapped
);

    localparam logic signed [11:0] HALF_TILE = 12'(2 ** (TILE_LOG2 - 1));
    localparam logic        [11:0] TILE_MASK = ~12'((2 ** TILE_LOG2) - 1);

    logic signed [11:0] rounded;

    // Twelve bits keep the rounding carry so the sign test never wraps.
    always_comb begin
        rounded = $signed({pos[10], pos}) + HALF_TILE;
        snapped = rounded[11] ? 11'd0 : (rounded[10:0] & TILE_MASK[10:0]);
    end

endmodule

// File: rtl/bomb_fuse.sv
// Bomb placement, fuse timing, final-second blinking and blast hand-off to the blast stage.
module bomb_fuse #(
    parameter int          FUSE_SEC     = 3,
    parameter int          TILE_LOG2    = bomb_pkg::TILE_LOG2,
    parameter int          BLINK_FRAMES = 8,
    parameter logic [1:0]  INIT_RADIUS  = 2'd1,
    parameter logic [10:0] OFF_X        = bomb_pkg::OFF_X,
    parameter logic [10:0] OFF_Y        = bomb_pkg::OFF_Y
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               OneSecPulse,
    input  logic               startOfFrame,
    input  logic               place,
    input  logic signed [10:0] player_topLeftX,
    input  logic signed [10:0] player_topLeftY,
    input  logic               radius_up,
    input  logic               chain_hit,
    input  logic               explode,
    output logic        [10:0] bomb_topLeftX,
    output logic        [10:0] bomb_topLeftY,
    output logic               bomb_visible,
    output logic               blast,
    output logic        [1:0]  blastRadius,
    output logic               busy
);
    import bomb_pkg::*;

    localparam logic [2:0] FUSE_LAST  = 3'(FUSE_SEC - 1);
    localparam logic [7:0] FRAME_LAST = 8'(BLINK_FRAMES - 1);

    state_t      state, state_n;
    logic [2:0]  fuse_cnt, fuse_n;
    logic [7:0]  frame_cnt, frame_n;
    logic        seen_explode, seen_n;
    logic        radius_pending, pending_n;
    logic [10:0] x_n, y_n, snap_x, snap_y;
    logic        visible_n, blast_n, busy_n;
    radius_t     radius_n;

    grid_snap #(.TILE_LOG2(TILE_LOG2)) u_snap_x (.pos(player_topLeftX), .snapped(snap_x));
    grid_snap #(.TILE_LOG2(TILE_LOG2)) u_snap_y (.pos(player_topLeftY), .snapped(snap_y));

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= s_idle;
            fuse_cnt       <= 3'd0;
            frame_cnt      <= 8'd0;
            seen_explode   <= 1'b0;
            radius_pending <= 1'b0;
            bomb_topLeftX  <= OFF_X;
            bomb_topLeftY  <= OFF_Y;
            bomb_visible   <= 1'b0;
            blast          <= 1'b0;
            blastRadius    <= INIT_RADIUS;
            busy           <= 1'b0;
        end else begin
            state          <= state_n;
            fuse_cnt       <= fuse_n;
            frame_cnt      <= frame_n;
            seen_explode   <= seen_n;
            radius_pending <= pending_n;
            bomb_topLeftX  <= x_n;
            bomb_topLeftY  <= y_n;
            bomb_visible   <= visible_n;
            blast          <= blast_n;
            blastRadius    <= radius_n;
            busy           <= busy_n;
        end
    end

    // Every output is computed here one cycle ahead and registered above.
    always_comb begin
        state_n   = state;
        fuse_n    = fuse_cnt;
        frame_n   = frame_cnt;
        seen_n    = seen_explode;
        pending_n = radius_pending;
        x_n       = bomb_topLeftX;
        y_n       = bomb_topLeftY;
        visible_n = bomb_visible;
        blast_n   = 1'b0;
        radius_n  = blastRadius;

        // The blast stage is still using the radius, so defer power-ups.
        if (radius_up) begin
            if (state == s_detonate || state == s_wait) begin
                pending_n = 1'b1;
            end else begin
                radius_n = radius_inc(blastRadius);
            end
        end

        case (state)
            s_idle: begin
                x_n       = OFF_X;
                y_n       = OFF_Y;
                visible_n = 1'b0;
                if (place) begin
                    x_n       = snap_x;
                    y_n       = snap_y;
                    fuse_n    = 3'd0;
                    visible_n = 1'b1;
                    state_n   = s_armed;
                end
            end
            s_armed: begin
                if (chain_hit) begin
                    state_n   = s_detonate;
                    blast_n   = 1'b1;
                    visible_n = 1'b0;
                end else if (fuse_cnt == FUSE_LAST) begin
                    frame_n = 8'd0;
                    state_n = s_blink;
                end else if (OneSecPulse) begin
                    fuse_n = fuse_cnt + 3'd1;
                    if (fuse_cnt + 3'd1 == FUSE_LAST) begin
                        frame_n = 8'd0;
                        state_n = s_blink;
                    end
                end
            end
            s_blink: begin
                if (chain_hit || OneSecPulse) begin
                    state_n   = s_detonate;
                    blast_n   = 1'b1;
                    visible_n = 1'b0;
                end else if (startOfFrame) begin
                    if (frame_cnt == FRAME_LAST) begin
                        frame_n   = 8'd0;
                        visible_n = ~bomb_visible;
                    end else begin
                        frame_n = frame_cnt + 8'd1;
                    end
                end
            end
            s_detonate: begin
                seen_n  = 1'b0;
                state_n = s_wait;
            end
            s_wait: begin
                if (explode) begin
                    seen_n = 1'b1;
                end
                if (seen_explode && !explode) begin
                    x_n       = OFF_X;
                    y_n       = OFF_Y;
                    visible_n = 1'b0;
                    if (radius_pending || radius_up) begin
                        radius_n = radius_inc(blastRadius);
                    end
                    pending_n = 1'b0;
                    state_n   = s_idle;
                end
            end
            default: state_n = s_idle;
        endcase

        busy_n = (state_n != s_idle);
    end

endmodule

// File: tb/tb_bomb_fuse.sv
// Directed self-checking bench for bomb_fuse with hand-computed expectations.
module tb_bomb_fuse;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               OneSecPulse = 1'b0;
    logic               startOfFrame = 1'b0;
    logic               place = 1'b0;
    logic signed [10:0] player_topLeftX = 11'sd0;
    logic signed [10:0] player_topLeftY = 11'sd0;
    logic               radius_up = 1'b0;
    logic               chain_hit = 1'b0;
    logic               explode = 1'b0;
    logic        [10:0] bomb_topLeftX;
    logic        [10:0] bomb_topLeftY;
    logic               bomb_visible;
    logic               blast;
    logic        [1:0]  blastRadius;
    logic               busy;

    int passed = 0;
    int total  = 0;
    int blasts = 0;

    bomb_fuse dut (
        .clk(clk), .reset(reset), .OneSecPulse(OneSecPulse), .startOfFrame(startOfFrame),
        .place(place), .player_topLeftX(player_topLeftX), .player_topLeftY(player_topLeftY),
        .radius_up(radius_up), .chain_hit(chain_hit), .explode(explode),
        .bomb_topLeftX(bomb_topLeftX), .bomb_topLeftY(bomb_topLeftY),
        .bomb_visible(bomb_visible), .blast(blast), .blastRadius(blastRadius), .busy(busy)
    );

    always #5 clk = ~clk;

    // Each blast cycle spans exactly one falling edge.
    always @(negedge clk) if (blast === 1'b1) blasts++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_explode();
        explode = 1'b1;
        tick();
        tick();
        explode = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++; if (bomb_topLeftX !== 11'd640) $display("[TB] FAIL reset_x: got %0d expected 640", bomb_topLeftX); else passed++;
        total++; if (bomb_topLeftY !== 11'd480) $display("[TB] FAIL reset_y: got %0d expected 480", bomb_topLeftY); else passed++;
        total++; if (bomb_visible !== 1'b0) $display("[TB] FAIL reset_visible: got %b expected 0", bomb_visible); else passed++;
        total++; if (blast !== 1'b0) $display("[TB] FAIL reset_blast: got %b expected 0", blast); else passed++;
        total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (blastRadius !== 2'd1) $display("[TB] FAIL reset_radius: got %0d expected 1", blastRadius); else passed++;
    endtask

    task automatic test_fuse();
        int b0;
        player_topLeftX = 11'sd47;
        player_topLeftY = 11'sd100;
        place = 1'b1;
        tick();
        place = 1'b0;
        total++; if (bomb_topLeftX !== 11'd32) $display("[TB] FAIL fuse_x: got %0d expected 32", bomb_topLeftX); else passed++;
        total++; if (bomb_topLeftY !== 11'd96) $display("[TB] FAIL fuse_y: got %0d expected 96", bomb_topLeftY); else passed++;
        total++; if (bomb_visible !== 1'b1) $display("[TB] FAIL fuse_visible: got %b expected 1", bomb_visible); else passed++;
        total++; if (busy !== 1'b1) $display("[TB] FAIL fuse_busy: got %b expected 1", busy); else passed++;
        OneSecPulse = 1'b1; tick(); OneSecPulse = 1'b0;
        tick(); tick();
        OneSecPulse = 1'b1; tick(); OneSecPulse = 1'b0;
        total++; if (blast !== 1'b0) $display("[TB] FAIL fuse_early_blast: got %b expected 0", blast); else passed++;
        for (int i = 0; i < 7; i++) begin
            startOfFrame = 1'b1; tick(); startOfFrame = 1'b0; tick();
        end
        total++; if (bomb_visible !== 1'b1) $display("[TB] FAIL blink_7_frames: got %b expected 1", bomb_visible); else passed++;
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
        total++; if (bomb_visible !== 1'b0) $display("[TB] FAIL blink_8_frames: got %b expected 0", bomb_visible); else passed++;
        b0 = blasts;
        OneSecPulse = 1'b1; tick(); OneSecPulse = 1'b0;
        total++; if (blast !== 1'b1) $display("[TB] FAIL fuse_blast: got %b expected 1", blast); else passed++;
        total++; if (blastRadius !== 2'd1) $display("[TB] FAIL fuse_radius: got %0d expected 1", blastRadius); else passed++;
        total++; if (bomb_topLeftX !== 11'd32) $display("[TB] FAIL fuse_blast_x: got %0d expected 32", bomb_topLeftX); else passed++;
        tick();
        total++; if (blast !== 1'b0) $display("[TB] FAIL fuse_blast_width: got %b expected 0", blast); else passed++;
        total++; if (bomb_topLeftY !== 11'd96) $display("[TB] FAIL fuse_hold_y: got %0d expected 96", bomb_topLeftY); else passed++;
        do_explode();
        total++; if (busy !== 1'b0) $display("[TB] FAIL fuse_idle_busy: got %b expected 0", busy); else passed++;
        total++; if (bomb_topLeftX !== 11'd640) $display("[TB] FAIL fuse_park_x: got %0d expected 640", bomb_topLeftX); else passed++;
        total++; if (blasts - b0 !== 1) $display("[TB] FAIL fuse_blast_count: got %0d expected 1", blasts - b0); else passed++;
    endtask

    task automatic test_chain();
        player_topLeftX = 11'sd200;
        player_topLeftY = 11'sd200;
        place = 1'b1; tick(); place = 1'b0;
        OneSecPulse = 1'b1; chain_hit = 1'b1; tick(); OneSecPulse = 1'b0; chain_hit = 1'b0;
        total++; if (blast !== 1'b1) $display("[TB] FAIL chain_blast: got %b expected 1", blast); else passed++;
        total++; if (bomb_topLeftX !== 11'd192) $display("[TB] FAIL chain_x: got %0d expected 192", bomb_topLeftX); else passed++;
        tick();
        total++; if (blast !== 1'b0) $display("[TB] FAIL chain_blast_width: got %b expected 0", blast); else passed++;
        do_explode();
        total++; if (busy !== 1'b0) $display("[TB] FAIL chain_idle: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_back_to_back();
        int b0;
        int drops;
        b0 = blasts;
        drops = 0;
        player_topLeftX = 11'sd64;
        player_topLeftY = 11'sd64;
        place = 1'b1;
        tick();
        chain_hit = 1'b1; tick(); chain_hit = 1'b0;
        tick(); tick();
        explode = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (busy !== 1'b1) drops++;
        end
        explode = 1'b0;
        tick();
        total++; if (busy !== 1'b0) $display("[TB] FAIL b2b_idle: got %b expected 0", busy); else passed++;
        total++; if (bomb_topLeftX !== 11'd640) $display("[TB] FAIL b2b_park_x: got %0d expected 640", bomb_topLeftX); else passed++;
        total++; if (drops !== 0) $display("[TB] FAIL b2b_early_rearm: got %0d expected 0", drops); else passed++;
        tick();
        total++; if (busy !== 1'b1) $display("[TB] FAIL b2b_rearm: got %b expected 1", busy); else passed++;
        total++; if (bomb_visible !== 1'b1) $display("[TB] FAIL b2b_visible: got %b expected 1", bomb_visible); else passed++;
        total++; if (bomb_topLeftX !== 11'd64) $display("[TB] FAIL b2b_x: got %0d expected 64", bomb_topLeftX); else passed++;
        total++; if (blasts - b0 !== 1) $display("[TB] FAIL b2b_blast_count: got %0d expected 1", blasts - b0); else passed++;
        place = 1'b0;
        chain_hit = 1'b1; tick(); chain_hit = 1'b0;
        tick();
        do_explode();
    endtask

    task automatic test_radius();
        logic [1:0] exp_r [4] = '{2'd2, 2'd3, 2'd3, 2'd3};
        reset = 1'b1; tick(); reset = 1'b0;
        total++; if (blastRadius !== 2'd1) $display("[TB] FAIL radius_init: got %0d expected 1", blastRadius); else passed++;
        for (int i = 0; i < 4; i++) begin
            radius_up = 1'b1; tick(); radius_up = 1'b0;
            total++; if (blastRadius !== exp_r[i]) $display("[TB] FAIL radius_up_%0d: got %0d expected %0d", i, blastRadius, exp_r[i]); else passed++;
        end
        reset = 1'b1; tick(); reset = 1'b0;
        player_topLeftX = 11'sd100;
        player_topLeftY = 11'sd100;
        place = 1'b1; tick(); place = 1'b0;
        chain_hit = 1'b1; tick(); chain_hit = 1'b0;
        tick();
        radius_up = 1'b1; tick(); radius_up = 1'b0;
        total++; if (blastRadius !== 2'd1) $display("[TB] FAIL radius_wait_held: got %0d expected 1", blastRadius); else passed++;
        total++; if (busy !== 1'b1) $display("[TB] FAIL radius_wait_busy: got %b expected 1", busy); else passed++;
        explode = 1'b1; tick(); explode = 1'b0; tick();
        total++; if (blastRadius !== 2'd2) $display("[TB] FAIL radius_applied: got %0d expected 2", blastRadius); else passed++;
        total++; if (busy !== 1'b0) $display("[TB] FAIL radius_idle: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_reset_blink();
        int b0;
        b0 = blasts;
        player_topLeftX = 11'sd47;
        player_topLeftY = 11'sd100;
        place = 1'b1; tick(); place = 1'b0;
        OneSecPulse = 1'b1; tick(); OneSecPulse = 1'b0;
        OneSecPulse = 1'b1; tick(); OneSecPulse = 1'b0;
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        total++; if (bomb_topLeftX !== 11'd640) $display("[TB] FAIL rstblink_x: got %0d expected 640", bomb_topLeftX); else passed++;
        total++; if (bomb_topLeftY !== 11'd480) $display("[TB] FAIL rstblink_y: got %0d expected 480", bomb_topLeftY); else passed++;
        total++; if (bomb_visible !== 1'b0) $display("[TB] FAIL rstblink_visible: got %b expected 0", bomb_visible); else passed++;
        total++; if (busy !== 1'b0) $display("[TB] FAIL rstblink_busy: got %b expected 0", busy); else passed++;
        total++; if (blastRadius !== 2'd1) $display("[TB] FAIL rstblink_radius: got %0d expected 1", blastRadius); else passed++;
        OneSecPulse = 1'b1; tick(); OneSecPulse = 1'b0;
        tick();
        total++; if (busy !== 1'b0) $display("[TB] FAIL rstblink_stay_idle: got %b expected 0", busy); else passed++;
        total++; if (blasts - b0 !== 0) $display("[TB] FAIL rstblink_no_blast: got %0d expected 0", blasts - b0); else passed++;
    endtask

    task automatic test_clamp();
        player_topLeftX = -11'sd10;
        player_topLeftY = 11'sd479;
        place = 1'b1; tick(); place = 1'b0;
        total++; if (bomb_topLeftX !== 11'd0) $display("[TB] FAIL clamp_x_m10: got %0d expected 0", bomb_topLeftX); else passed++;
        total++; if (bomb_topLeftY !== 11'd480) $display("[TB] FAIL snap_y_479: got %0d expected 480", bomb_topLeftY); else passed++;
        chain_hit = 1'b1; tick(); chain_hit = 1'b0;
        do_explode();
        player_topLeftX = -11'sd40;
        player_topLeftY = 11'sd1023;
        place = 1'b1; tick(); place = 1'b0;
        total++; if (bomb_topLeftX !== 11'd0) $display("[TB] FAIL clamp_x_m40: got %0d expected 0", bomb_topLeftX); else passed++;
        total++; if (bomb_topLeftY !== 11'd1024) $display("[TB] FAIL snap_y_1023: got %0d expected 1024", bomb_topLeftY); else passed++;
        chain_hit = 1'b1; tick(); chain_hit = 1'b0;
        do_explode();
    endtask

    initial begin
        test_reset();
        test_fuse();
        test_chain();
        test_back_to_back();
        test_radius();
        test_reset_blink();
        test_clamp();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
